// File: rtl/i_fetch.sv
// Instruction-fetch stage: owns the PC, handshakes with the instruction cache and
// writes {pc, instruction, valid, rvfi seed} into the IF/ID buffer consumed by i_decode.
package i_fetch_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned ORDER_W = 64;

  typedef struct packed {
    logic [XLEN-1:0] word;
  } instr_t;

  typedef struct packed {
    logic               valid;
    logic [ORDER_W-1:0] order;
    logic [XLEN-1:0]    inst;
    logic               trap;
    logic               halt;
    logic               intr;
    logic [1:0]         mode;
    logic [1:0]         ixl;
    logic [4:0]         rs1_addr;
    logic [4:0]         rs2_addr;
    logic [XLEN-1:0]    rs1_rdata;
    logic [XLEN-1:0]    rs2_rdata;
    logic [4:0]         rd_addr;
    logic [XLEN-1:0]    rd_wdata;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
    logic [XLEN-1:0]    mem_addr;
    logic [3:0]         mem_rmask;
    logic [3:0]         mem_wmask;
    logic [XLEN-1:0]    mem_rdata;
    logic [XLEN-1:0]    mem_wdata;
  } rvfi_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    instr_t          ir;
    logic            valid;
    rvfi_t           rvfi_d;
  } IF_ID_stage_t;
endpackage

module i_fetch
  import i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_read,
  output logic [31:0]  imem_address,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_resp,
  input  logic         stall,
  input  logic         branch_take,
  input  logic [31:0]  branch_target,
  output IF_ID_stage_t if_out
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } state_t;

  state_t             state;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    addr_q;
  logic [XLEN-1:0]    skid_word;
  logic               read_q;
  logic [ORDER_W-1:0] order_q;
  IF_ID_stage_t       ifid_q;

  logic [XLEN-1:0]    target;
  logic [XLEN-1:0]    pc_inc;
  logic               resp;

  // Builds an IF/ID entry with its rvfi seed; fields decode fills in later stay zero.
  function automatic IF_ID_stage_t make_ifid(input logic [XLEN-1:0] pc,
                                             input logic [XLEN-1:0] word,
                                             input logic valid,
                                             input logic [ORDER_W-1:0] order);
    IF_ID_stage_t r;
    r                 = '0;
    r.pc              = pc;
    r.ir.word         = word;
    r.valid           = valid;
    r.rvfi_d.pc_rdata = pc;
    r.rvfi_d.pc_wdata = XLEN'(pc + XLEN'(4));
    r.rvfi_d.inst     = word;
    r.rvfi_d.valid    = valid;
    r.rvfi_d.order    = order;
    return r;
  endfunction

  assign target       = branch_target & ~XLEN'(3);
  assign pc_inc       = XLEN'(pc_q + XLEN'(4));
  assign resp         = imem_resp & read_q;
  // Request is forced low for the whole reset cycle, not just after the edge.
  assign imem_read    = read_q & rst;
  assign imem_address = addr_q;
  assign if_out       = ifid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= FETCH;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      read_q    <= 1'b1;
      skid_word <= NOP_INSTR;
      order_q   <= '0;
      ifid_q    <= make_ifid('0, NOP_INSTR, 1'b0, '0);
    end else if (branch_take) begin
      // Redirect wins over stall and response; a live request without a response must drain.
      pc_q      <= target;
      read_q    <= 1'b1;
      skid_word <= NOP_INSTR;
      ifid_q    <= make_ifid('0, NOP_INSTR, 1'b0, order_q);
      if (state == HOLD || resp) begin
        state  <= FETCH;
        addr_q <= target;
      end else begin
        state  <= KILL;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (resp) begin
            if (stall) begin
              skid_word <= imem_rdata;
              read_q    <= 1'b0;
              state     <= HOLD;
            end else begin
              ifid_q  <= make_ifid(pc_q, imem_rdata, 1'b1, order_q);
              order_q <= order_q + ORDER_W'(1);
              pc_q    <= pc_inc;
              addr_q  <= pc_inc;
            end
          end else if (!stall) begin
            ifid_q <= make_ifid('0, NOP_INSTR, 1'b0, order_q);
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_q  <= make_ifid(pc_q, skid_word, 1'b1, order_q);
            order_q <= order_q + ORDER_W'(1);
            pc_q    <= pc_inc;
            addr_q  <= pc_inc;
            read_q  <= 1'b1;
            state   <= FETCH;
          end
        end
        KILL: begin
          // Old address stays on the bus until the cache answers; that word is dropped.
          if (resp) begin
            addr_q <= pc_q;
            state  <= FETCH;
          end
          if (!stall) begin
            ifid_q <= make_ifid('0, NOP_INSTR, 1'b0, order_q);
          end
        end
        default: begin
          state  <= FETCH;
          read_q <= 1'b1;
          addr_q <= pc_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_fetch.sv
// Scoreboard bench for i_fetch: directed cache/stall/branch vectors; expected IF/ID
// loads are queued by the stimulus and checked by an independent monitor.
module tb_i_fetch;
  import i_fetch_pkg::*;

  logic         clk;
  logic         rst;
  logic         imem_read;
  logic [31:0]  imem_address;
  logic [31:0]  imem_rdata;
  logic         imem_resp;
  logic         stall;
  logic         branch_take;
  logic [31:0]  branch_target;
  IF_ID_stage_t if_out;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [63:0] order;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_valid = 1'b0;
  logic [63:0] last_order = '0;

  i_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall        (stall),
    .branch_take  (branch_take),
    .branch_target(branch_target),
    .if_out       (if_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_load(input logic [31:0] pc, input logic [63:0] order);
    exp_t x;
    x.pc    = pc;
    x.word  = word_of(pc);
    x.order = order;
    sb.push_back(x);
  endtask

  // One clock of stimulus; the cache answers with a word derived from the presented address.
  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t);
    imem_resp     = r;
    stall         = s;
    branch_take   = b;
    branch_target = t;
    imem_rdata    = word_of(imem_address);
    @(posedge clk);
    #1;
    imem_resp   = 1'b0;
    stall       = 1'b0;
    branch_take = 1'b0;
  endtask

  // Monitor: every fresh valid IF/ID load is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst === 1'b1 && if_out.valid === 1'b1 &&
        (!prev_valid || if_out.rvfi_d.order !== last_order)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: load pc %h order %0d with no expected entry",
                 if_out.pc, if_out.rvfi_d.order);
      end else begin
        e = sb.pop_front();
        if (if_out.pc !== e.pc || if_out.ir.word !== e.word ||
            if_out.rvfi_d.order !== e.order || if_out.rvfi_d.pc_rdata !== e.pc ||
            if_out.rvfi_d.pc_wdata !== 32'(e.pc + 32'd4) ||
            if_out.rvfi_d.inst !== e.word || if_out.rvfi_d.valid !== 1'b1) begin
          n_fail++;
          $display("FAIL sb_load: got pc %h ir %h order %0d wdata %h, expected pc %h ir %h order %0d",
                   if_out.pc, if_out.ir.word, if_out.rvfi_d.order, if_out.rvfi_d.pc_wdata,
                   e.pc, e.word, e.order);
        end
      end
    end
    prev_valid = (if_out.valid === 1'b1);
    last_order = if_out.rvfi_d.order;
  end

  initial begin
    rst = 1'b0;
    imem_resp = 1'b0;
    imem_rdata = '0;
    stall = 1'b0;
    branch_take = 1'b0;
    branch_target = '0;

    // Reset state
    repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_read", 64'(imem_read), 64'd0);
    check("rst_valid", 64'(if_out.valid), 64'd0);
    check("rst_ir", 64'(if_out.ir.word), 64'h13);
    check("rst_pc", 64'(if_out.pc), 64'd0);
    check("rst_order", if_out.rvfi_d.order, 64'd0);
    rst = 1'b1;
    #1;
    check("first_read", 64'(imem_read), 64'd1);
    check("first_addr", 64'(imem_address), 64'h4000_0000);

    // Back-to-back responses, one instruction per cycle
    for (int i = 0; i < 3; i++) begin
      expect_load(32'h4000_0000 + 32'(i * 4), 64'(i));
      drive(1'b1, 1'b0, 1'b0, 32'h0);
    end
    check("b2b_addr", 64'(imem_address), 64'h4000_000C);

    // Slow cache: address held, bubbles in between
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      check("slow_addr", 64'(imem_address), 64'h4000_000C);
      check("slow_bubble_valid", 64'(if_out.valid), 64'd0);
      check("slow_bubble_ir", 64'(if_out.ir.word), 64'h13);
    end
    expect_load(32'h4000_000C, 64'd3);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_load(32'h4000_0010, 64'd4);
    drive(1'b1, 1'b0, 1'b0, 32'h0);

    // Stall as the response for 0x14 arrives
    expect_load(32'h4000_0014, 64'd5);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("hold_read", 64'(imem_read), 64'd0);
    check("hold_ifid_pc", 64'(if_out.pc), 64'h4000_0010);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("hold2_read", 64'(imem_read), 64'd0);
    check("hold2_ifid_pc", 64'(if_out.pc), 64'h4000_0010);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("unhold_ifid_pc", 64'(if_out.pc), 64'h4000_0014);
    check("unhold_addr", 64'(imem_address), 64'h4000_0018);
    check("unhold_read", 64'(imem_read), 64'd1);

    // Branch while fetch of 0x18 outstanding: drain stale fetch
    drive(1'b0, 1'b0, 1'b1, 32'h4000_0100);
    check("kill_bubble", 64'(if_out.valid), 64'd0);
    check("kill_addr", 64'(imem_address), 64'h4000_0018);
    check("kill_read", 64'(imem_read), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("kill_addr2", 64'(imem_address), 64'h4000_0018);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("kill_redirect_addr", 64'(imem_address), 64'h4000_0100);
    check("kill_drop_valid", 64'(if_out.valid), 64'd0);
    expect_load(32'h4000_0100, 64'd6);
    drive(1'b1, 1'b0, 1'b0, 32'h0);

    // Branch coincident with response and stall, unaligned target
    drive(1'b1, 1'b1, 1'b1, 32'h4000_0203);
    check("brresp_valid", 64'(if_out.valid), 64'd0);
    check("brresp_read", 64'(imem_read), 64'd1);
    check("brresp_addr", 64'(imem_address), 64'h4000_0200);
    expect_load(32'h4000_0200, 64'd7);
    drive(1'b1, 1'b0, 1'b0, 32'h0);

    // PC wrap at top of address space
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_addr0", 64'(imem_address), 64'hFFFF_FFFC);
    expect_load(32'hFFFF_FFFC, 64'd8);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", 64'(imem_address), 64'h0);

    // Reset in the middle of a KILL drain
    drive(1'b0, 1'b0, 1'b1, 32'h4000_0300);
    check("kill2_addr", 64'(imem_address), 64'h0);
    rst = 1'b0;
    #1;
    check("rst_mid_read", 64'(imem_read), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("rerst_addr", 64'(imem_address), 64'h4000_0000);
    check("rerst_read", 64'(imem_read), 64'd1);
    check("rerst_valid", 64'(if_out.valid), 64'd0);
    expect_load(32'h4000_0000, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
